sha256_round_core: RTL and testbench

SHA-256 compression engine: loads a 512-bit message block and 256-bit chaining value, runs the 64 compression rounds one per clock with an internal message schedule, and presents the final working variables a..h. Sits directly upstream of the per-word hash registers (H1..H8). Each register adds its word (a for H1, b for H2, …) to its running value when this block signals `done`.

---
 rtl/sha256_round_core_if.sv | 38 +++
 rtl/sha256_round_core.sv | 145 ++++++++++++++
 tb/tb_sha256_round_core.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_core_if.sv
// Handshake and data bundle between a SHA-256 block source and sha256_round_core.
// The abort wire exists only when SHA_ABORT_EN is defined.
interface sha256_round_core_if;
  logic         start;
  logic [511:0] msg;
  logic [255:0] hin;
  logic         busy;
  logic         done;
  logic [31:0]  a_out;
  logic [31:0]  b_out;
  logic [31:0]  c_out;
  logic [31:0]  d_out;
  logic [31:0]  e_out;
  logic [31:0]  f_out;
  logic [31:0]  g_out;
  logic [31:0]  h_out;
`ifdef SHA_ABORT_EN
  logic         abort;

  modport master (
    output start, msg, hin, abort,
    input  busy, done, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out
  );
  modport slave (
    input  start, msg, hin, abort,
    output busy, done, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out
  );
`else
  modport master (
    output start, msg, hin,
    input  busy, done, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out
  );
  modport slave (
    input  start, msg, hin,
    output busy, done, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out
  );
`endif
endinterface

// File: rtl/sha256_round_core.sv
// SHA-256 compression core: 64 rounds, one per clock, with a rolling 16-word message
// schedule. Optional feature macro: SHA_ABORT_EN adds an abort input that drops RUN to IDLE.
module sha256_round_core (
  input  logic                clk,
  input  logic                rst_n,
  sha256_round_core_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [5:0]  t_q;
  logic        busy_q, done_q;
  logic [31:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0] w_q [16];

  logic [31:0] k_t, big_s0, big_s1, ch, maj, t1, t2, sig0, sig1, w_new;
  logic        abort_run;

`ifdef SHA_ABORT_EN
  assign abort_run = bus.abort;
`else
  assign abort_run = 1'b0;
`endif

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.c_out = c_q;
  assign bus.d_out = d_q;
  assign bus.e_out = e_q;
  assign bus.f_out = f_q;
  assign bus.g_out = g_q;
  assign bus.h_out = h_q;

  // Round constant ROM indexed by the round counter.
  always_comb begin
    k_t = '0;
    case (t_q)
      6'd0:  k_t = 32'h428a2f98;  6'd1:  k_t = 32'h71374491;
      6'd2:  k_t = 32'hb5c0fbcf;  6'd3:  k_t = 32'he9b5dba5;
      6'd4:  k_t = 32'h3956c25b;  6'd5:  k_t = 32'h59f111f1;
      6'd6:  k_t = 32'h923f82a4;  6'd7:  k_t = 32'hab1c5ed5;
      6'd8:  k_t = 32'hd807aa98;  6'd9:  k_t = 32'h12835b01;
      6'd10: k_t = 32'h243185be;  6'd11: k_t = 32'h550c7dc3;
      6'd12: k_t = 32'h72be5d74;  6'd13: k_t = 32'h80deb1fe;
      6'd14: k_t = 32'h9bdc06a7;  6'd15: k_t = 32'hc19bf174;
      6'd16: k_t = 32'he49b69c1;  6'd17: k_t = 32'hefbe4786;
      6'd18: k_t = 32'h0fc19dc6;  6'd19: k_t = 32'h240ca1cc;
      6'd20: k_t = 32'h2de92c6f;  6'd21: k_t = 32'h4a7484aa;
      6'd22: k_t = 32'h5cb0a9dc;  6'd23: k_t = 32'h76f988da;
      6'd24: k_t = 32'h983e5152;  6'd25: k_t = 32'ha831c66d;
      6'd26: k_t = 32'hb00327c8;  6'd27: k_t = 32'hbf597fc7;
      6'd28: k_t = 32'hc6e00bf3;  6'd29: k_t = 32'hd5a79147;
      6'd30: k_t = 32'h06ca6351;  6'd31: k_t = 32'h14292967;
      6'd32: k_t = 32'h27b70a85;  6'd33: k_t = 32'h2e1b2138;
      6'd34: k_t = 32'h4d2c6dfc;  6'd35: k_t = 32'h53380d13;
      6'd36: k_t = 32'h650a7354;  6'd37: k_t = 32'h766a0abb;
      6'd38: k_t = 32'h81c2c92e;  6'd39: k_t = 32'h92722c85;
      6'd40: k_t = 32'ha2bfe8a1;  6'd41: k_t = 32'ha81a664b;
      6'd42: k_t = 32'hc24b8b70;  6'd43: k_t = 32'hc76c51a3;
      6'd44: k_t = 32'hd192e819;  6'd45: k_t = 32'hd6990624;
      6'd46: k_t = 32'hf40e3585;  6'd47: k_t = 32'h106aa070;
      6'd48: k_t = 32'h19a4c116;  6'd49: k_t = 32'h1e376c08;
      6'd50: k_t = 32'h2748774c;  6'd51: k_t = 32'h34b0bcb5;
      6'd52: k_t = 32'h391c0cb3;  6'd53: k_t = 32'h4ed8aa4a;
      6'd54: k_t = 32'h5b9cca4f;  6'd55: k_t = 32'h682e6ff3;
      6'd56: k_t = 32'h748f82ee;  6'd57: k_t = 32'h78a5636f;
      6'd58: k_t = 32'h84c87814;  6'd59: k_t = 32'h8cc70208;
      6'd60: k_t = 32'h90befffa;  6'd61: k_t = 32'ha4506ceb;
      6'd62: k_t = 32'hbef9a3f7;  6'd63: k_t = 32'hc67178f2;
      default: k_t = '0;
    endcase
  end

  // Round datapath plus next schedule word. w_q[0] always holds W[t]; the word shifted in
  // at the top is W[t+16] (words computed during rounds 48..63 are never consumed).
  always_comb begin
    big_s1 = {e_q[5:0], e_q[31:6]} ^ {e_q[10:0], e_q[31:11]} ^ {e_q[24:0], e_q[31:25]};
    big_s0 = {a_q[1:0], a_q[31:2]} ^ {a_q[12:0], a_q[31:13]} ^ {a_q[21:0], a_q[31:22]};
    ch     = (e_q & f_q) ^ (~e_q & g_q);
    maj    = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
    t1     = h_q + big_s1 + ch + k_t + w_q[0];
    t2     = big_s0 + maj;
    sig0   = {w_q[1][6:0], w_q[1][31:7]} ^ {w_q[1][17:0], w_q[1][31:18]} ^ (w_q[1] >> 3);
    sig1   = {w_q[14][16:0], w_q[14][31:17]} ^ {w_q[14][18:0], w_q[14][31:19]}
           ^ (w_q[14] >> 10);
    w_new  = sig1 + w_q[9] + sig0 + w_q[0];
  end

  // Control FSM, working variables and schedule window; busy/done are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // start beats a simultaneous abort here: abort is only looked at in RUN
          if (bus.start) begin
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= bus.hin;
            for (int i = 0; i < 16; i++) w_q[i] <= bus.msg[511 - 32*i -: 32];
            t_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (abort_run) begin
            // Partial a..h are left visible on the outputs.
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            h_q <= g_q;
            g_q <= f_q;
            f_q <= e_q;
            e_q <= d_q + t1;
            d_q <= c_q;
            c_q <= b_q;
            b_q <= a_q;
            a_q <= t1 + t2;
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_new;
            t_q     <= t_q + 6'd1;
            if (t_q == 6'd63) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_core.sv
// Directed bench for sha256_round_core: table of blocks plus hand-written corner sequences
// (reset mid-run, start while busy, back-to-back, and abort when SHA_ABORT_EN is defined).
module tb_sha256_round_core;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC_MSG = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_EXP =
    256'h506e3058_d39a2165_04d24d6c_b85e2ce9_5ef50f24_fb121210_948d25b6_961f4894;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    string        name;
    logic [511:0] msg;
    logic [255:0] hin;
    logic [255:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  int   done_cnt;

  sha256_round_core_if bus ();

  sha256_round_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done is registered, so each one-cycle pulse is seen by exactly one rising edge.
  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression from the textbook definition: full 64-entry schedule up front.
  function automatic logic [255:0] model(input logic [511:0] m, input logic [255:0] hv);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] x1, x2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  function automatic logic [255:0] outs();
    return {bus.a_out, bus.b_out, bus.c_out, bus.d_out,
            bus.e_out, bus.f_out, bus.g_out, bus.h_out};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the next rising edge accepts. Returns at the falling edge
  // right after the accepting edge, with msg/hin scrambled to prove they are not re-read.
  task automatic launch(input logic [511:0] m, input logic [255:0] hv);
    bus.start = 1'b1;
    bus.msg   = m;
    bus.hin   = hv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.msg   = {16{32'hdeadbeef}};
    bus.hin   = {8{32'h0badf00d}};
  endtask

  // k0 = falling edges elapsed since the accepting edge. Checks latency, result, busy
  // timing and that outputs hold across the cycle after done. If poke, start is pulsed
  // during the done cycle with other inputs and must be ignored.
  task automatic wait_done(input int k0, input logic [255:0] exp, input string name,
                           input bit poke);
    int k;
    int c0;
    logic [255:0] res;
    k  = k0;
    c0 = done_cnt;
    while (bus.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 63) check({name, "_busy63"}, 256'(bus.busy), 256'd1);
    end
    check({name, "_latency"}, 256'(k), 256'd64);
    res = outs();
    check({name, "_result"}, res, exp);
    check({name, "_busy_in_done"}, 256'(bus.busy), 256'd0);
    if (poke) begin
      bus.start = 1'b1;
      bus.msg   = {16{32'h12345678}};
      bus.hin   = ~IV;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_done_width"}, 256'(bus.done), 256'd0);
    check({name, "_busy_after"}, 256'(bus.busy), 256'd0);
    check({name, "_hold"}, outs(), exp);
    check({name, "_done_count"}, 256'(done_cnt), 256'(c0 + 1));
  endtask

  vec_t         vecs [4];
  logic [511:0] pm;
  logic [255:0] exp_b;
  int           c0;

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    bus.msg   = '0;
    bus.hin   = '0;
`ifdef SHA_ABORT_EN
    bus.abort = 1'b0;
`endif

    for (int i = 0; i < 16; i++) pm[511 - 32*i -: 32] = 32'(i + 1) * 32'h01010101;
    vecs[0] = '{name: "abc",      msg: ABC_MSG,     hin: IV,          exp: ABC_EXP};
    vecs[1] = '{name: "all_ones", msg: {512{1'b1}}, hin: {256{1'b1}}, exp: '0};
    vecs[2] = '{name: "zero_msg", msg: '0,          hin: IV,          exp: '0};
    vecs[3] = '{name: "pattern",  msg: pm,          hin: ~IV,         exp: '0};
    for (int i = 1; i < 4; i++) vecs[i].exp = model(vecs[i].msg, vecs[i].hin);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), '0);
    check("reset_busy", 256'(bus.busy), 256'd0);
    check("reset_done", 256'(bus.done), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" with first-round detail.
    launch(ABC_MSG, IV);
    check("abc_load", outs(), IV);
    check("abc_busy0", 256'(bus.busy), 256'd1);
    @(negedge clk);
    check("abc_round0_a", 256'(bus.a_out), 256'h5d6aebcd);
    check("abc_round0_e", 256'(bus.e_out), 256'hfa2a4622);
    wait_done(1, ABC_EXP, "abc", 1'b0);
    @(negedge clk);

    // Table of blocks.
    for (int i = 0; i < 4; i++) begin
      launch(vecs[i].msg, vecs[i].hin);
      wait_done(0, vecs[i].exp, vecs[i].name, 1'b0);
      @(negedge clk);
    end

    // start while busy (round 20) and during DONE is ignored.
    launch(ABC_MSG, IV);
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    bus.msg   = {16{32'h55aa55aa}};
    bus.hin   = ~IV;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(21, ABC_EXP, "busy_start", 1'b1);
    @(negedge clk);
    check("busy_start_idle", 256'(bus.busy), 256'd0);

    // Reset in the middle of RUN.
    launch(ABC_MSG, IV);
    repeat (30) @(negedge clk);
    c0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", outs(), '0);
    check("midrst_busy", 256'(bus.busy), 256'd0);
    check("midrst_done", 256'(bus.done), 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("midrst_no_done", 256'(done_cnt), 256'(c0));
    check("midrst_stay_idle", 256'(bus.busy), 256'd0);
    check("midrst_outs_after", outs(), '0);

    // Back-to-back with start held high.
    exp_b = model(pm, IV);
    c0 = done_cnt;
    bus.start = 1'b1;
    bus.msg   = ABC_MSG;
    bus.hin   = IV;
    @(negedge clk);
    bus.msg = pm;
    bus.hin = IV;
    wait_done(0, ABC_EXP, "b2b_first", 1'b0);
    bus.start = 1'b1;  // wait_done drops start after the done cycle; keep it held
    @(negedge clk);
    check("b2b_reaccept", 256'(bus.busy), 256'd1);
    bus.start = 1'b0;
    wait_done(0, exp_b, "b2b_second", 1'b0);
    check("b2b_two_dones", 256'(done_cnt), 256'(c0 + 2));
    @(negedge clk);

`ifdef SHA_ABORT_EN
    // Abort at round 10, then a clean run.
    launch(ABC_MSG, IV);
    repeat (10) @(negedge clk);
    c0 = done_cnt;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 256'(bus.busy), 256'd0);
    check("abort_done", 256'(bus.done), 256'd0);
    repeat (70) @(negedge clk);
    check("abort_no_done", 256'(done_cnt), 256'(c0));
    // start wins over abort in IDLE.
    bus.abort = 1'b1;
    launch(ABC_MSG, IV);
    bus.abort = 1'b0;
    check("abort_start_wins", 256'(bus.busy), 256'd1);
    wait_done(0, ABC_EXP, "after_abort", 1'b0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
